// File: rtl/frontend_sweep_controller.sv
// Frequency sweep sequencer for the ADC/DAC frontend: steps the phase
// increment, waits for feedback match and settle, captures SIN/COS pairs.
module frontend_sweep_controller #(
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int RESULT_MUL_ACC_WIDTH = 32,
  parameter int SETTLE_BITS          = 16,
  parameter int STEP_COUNT_BITS      = 10
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic                                   START,
  input  logic                                   ABORT,
  input  logic [PHASE_INCREMENT_BITS-1:0]        CFG_START_INC,
  input  logic [PHASE_INCREMENT_BITS-1:0]        CFG_STEP_INC,
  input  logic [STEP_COUNT_BITS-1:0]             CFG_STEP_COUNT,
  input  logic [SETTLE_BITS-1:0]                 CFG_SETTLE,
  output logic [PHASE_INCREMENT_BITS-1:0]        PHASE_INCREMENT_OUT,
  input  logic [PHASE_INCREMENT_BITS-1:0]        CURRENT_PHASE_INCREMENT,
  input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
  input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
  output logic                                   RESULT_VALID,
  input  logic                                   RESULT_READY,
  output logic [STEP_COUNT_BITS-1:0]             RESULT_INDEX,
  output logic [PHASE_INCREMENT_BITS-1:0]        RESULT_PHASE_INC,
  output logic signed [RESULT_MUL_ACC_WIDTH-1:0] RESULT_SIN,
  output logic signed [RESULT_MUL_ACC_WIDTH-1:0] RESULT_COS,
  output logic                                   BUSY,
  output logic                                   DONE
);

  localparam int PIB = PHASE_INCREMENT_BITS;
  localparam int RMW = RESULT_MUL_ACC_WIDTH;
  localparam int SB  = SETTLE_BITS;
  localparam int SCB = STEP_COUNT_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE,
    S_CAPT,
    S_OUT
  } state_t;

  state_t                 state_q;
  logic [PIB-1:0]         phase_q;
  logic [PIB-1:0]         step_q;
  logic [SCB-1:0]         count_q;
  logic [SB-1:0]          settle_q;
  logic [SB-1:0]          cnt_q;
  logic [SCB-1:0]         idx_q;
  logic                   valid_q;
  logic                   done_q;
  logic                   busy_q;
  logic [SCB-1:0]         res_idx_q;
  logic [PIB-1:0]         res_inc_q;
  logic signed [RMW-1:0]  res_sin_q;
  logic signed [RMW-1:0]  res_cos_q;

  logic match;
  logic last;

  assign match = CE && (CURRENT_PHASE_INCREMENT == phase_q);
  assign last  = (idx_q == count_q - SCB'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      count_q   <= '0;
      settle_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      res_idx_q <= '0;
      res_inc_q <= '0;
      res_sin_q <= '0;
      res_cos_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (ABORT) begin
        // Abort drops any pending point; the phase word is left as-is.
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (START) begin
              if (CFG_STEP_COUNT == '0) begin
                done_q <= 1'b1;
              end else begin
                phase_q  <= CFG_START_INC;
                step_q   <= CFG_STEP_INC;
                count_q  <= CFG_STEP_COUNT;
                settle_q <= CFG_SETTLE;
                idx_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (match) begin
              cnt_q <= settle_q;
              if (settle_q == '0) begin
                state_q <= S_CAPT;
              end else begin
                state_q <= S_SETTLE;
              end
            end
          end
          S_SETTLE: begin
            if (CE) begin
              cnt_q <= cnt_q - SB'(1);
              if (cnt_q == SB'(1)) begin
                state_q <= S_CAPT;
              end
            end
          end
          S_CAPT: begin
            if (CE) begin
              res_idx_q <= idx_q;
              res_inc_q <= phase_q;
              res_sin_q <= SIN_MUL_ACC;
              res_cos_q <= COS_MUL_ACC;
              valid_q   <= 1'b1;
              state_q   <= S_OUT;
            end
          end
          S_OUT: begin
            if (valid_q && RESULT_READY) begin
              valid_q <= 1'b0;
              if (last) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                phase_q <= phase_q + step_q;
                idx_q   <= idx_q + SCB'(1);
                state_q <= S_WAIT;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PHASE_INCREMENT_OUT = phase_q;
  assign RESULT_VALID        = valid_q;
  assign RESULT_INDEX        = res_idx_q;
  assign RESULT_PHASE_INC    = res_inc_q;
  assign RESULT_SIN          = res_sin_q;
  assign RESULT_COS          = res_cos_q;
  assign BUSY                = busy_q;
  assign DONE                = done_q;

endmodule

// File: tb/tb_frontend_sweep_controller.sv
// Directed bench for frontend_sweep_controller: sweep, backpressure,
// edge configurations, abort and CE stall.
module tb_frontend_sweep_controller;

  localparam int PIB = 28;
  localparam int RMW = 32;
  localparam int SB  = 16;
  localparam int SCB = 10;

  logic CLK = 1'b0;
  logic RESET, CE, START, ABORT, READY;
  logic [PIB-1:0] cfg_start, cfg_step;
  logic [SCB-1:0] cfg_count;
  logic [SB-1:0]  cfg_settle;
  logic [PIB-1:0] OUT, CURR;
  logic signed [RMW-1:0] SIN, COS;
  logic VALID, BUSY, DONE;
  logic [SCB-1:0] R_IDX;
  logic [PIB-1:0] R_INC;
  logic signed [RMW-1:0] R_SIN, R_COS;

  frontend_sweep_controller dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .START(START), .ABORT(ABORT),
    .CFG_START_INC(cfg_start), .CFG_STEP_INC(cfg_step),
    .CFG_STEP_COUNT(cfg_count), .CFG_SETTLE(cfg_settle),
    .PHASE_INCREMENT_OUT(OUT), .CURRENT_PHASE_INCREMENT(CURR),
    .SIN_MUL_ACC(SIN), .COS_MUL_ACC(COS),
    .RESULT_VALID(VALID), .RESULT_READY(READY),
    .RESULT_INDEX(R_IDX), .RESULT_PHASE_INC(R_INC),
    .RESULT_SIN(R_SIN), .RESULT_COS(R_COS),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // CE generator and 8-tick feedback delay line standing in for the frontend
  int   ce_div = 4;
  logic ce_en  = 1'b1;
  int   ce_cnt = 0;
  logic [PIB-1:0] fb [8];

  always @(posedge CLK) ce_cnt <= (ce_cnt + 1) % ce_div;
  assign CE = ce_en && (ce_cnt == 0);

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) fb[i] <= '0;
    end else if (CE) begin
      fb[0] <= OUT;
      for (int i = 1; i < 8; i++) fb[i] <= fb[i-1];
    end
  end
  assign CURR = fb[7];
  assign SIN  = {4'hA, OUT};
  assign COS  = {4'h5, ~OUT};

  typedef struct packed {
    logic [SCB-1:0] idx;
    logic [PIB-1:0] inc;
    logic [RMW-1:0] s;
    logic [RMW-1:0] c;
  } res_t;

  res_t res_q[$];
  int   gap_q[$];
  int   done_cnt = 0;
  int   ticks = 0;
  int   match_tick = 0;
  logic armed = 1'b0;
  logic valid_prev = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (VALID && !valid_prev) gap_q.push_back(ticks - match_tick);
    valid_prev = VALID;
    if (VALID && READY && !ABORT)
      res_q.push_back('{R_IDX, R_INC, R_SIN, R_COS});
    if (DONE) done_cnt++;
    if (CE) begin
      ticks++;
      if (armed && BUSY && !VALID && CURR == OUT) begin
        match_tick = ticks;
        armed = 1'b0;
      end
    end
    if (VALID && READY && !ABORT) armed = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_sweep(input logic [PIB-1:0] inc,
                             input logic [PIB-1:0] step,
                             input logic [SCB-1:0] cnt,
                             input logic [SB-1:0] settle);
    cfg_start = inc; cfg_step = step;
    cfg_count = cnt; cfg_settle = settle;
    START = 1'b1;
    tick(1);
    START = 1'b0;
    armed = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (VALID) break;
    end
    if (i == maxc) chk(tag, 0, 1);
    tick(0);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (DONE) break;
    end
    if (i == maxc) chk(tag, 0, 1);
    tick(2);
  endtask

  task automatic wait_match(input string tag, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge CLK);
      #1;
      if (!armed) break;
    end
    if (i == maxc) chk(tag, 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_res(input string tag, input int k,
                         input logic [SCB-1:0] idx,
                         input logic [PIB-1:0] inc);
    if (k >= res_q.size()) begin
      chk({tag, "_missing"}, 0, 1);
    end else begin
      chk({tag, "_idx"}, 64'(res_q[k].idx), 64'(idx));
      chk({tag, "_inc"}, 64'(res_q[k].inc), 64'(inc));
      chk({tag, "_sin"}, 64'(res_q[k].s), 64'({4'hA, inc}));
      chk({tag, "_cos"}, 64'(res_q[k].c), 64'({4'h5, ~inc}));
    end
  endtask

  initial begin
    int d0, bad;
    logic [PIB-1:0] o_snap;
    res_t snap;

    RESET = 1'b1; START = 1'b1; ABORT = 1'b0; READY = 1'b1;
    cfg_start = 28'h0100000; cfg_step = 28'h1000;
    cfg_count = 10'd3; cfg_settle = 16'd4;
    tick(2);
    RESET = 1'b0; START = 1'b0;
    chk("rst_out", 64'(OUT), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_valid", 64'(VALID), 0);
    chk("rst_done", 64'(DONE), 0);
    chk("rst_res", 64'({R_IDX, R_INC}), 0);
    tick(3);
    chk("rst_start_ignored", 64'(BUSY), 0);

    // Sweep of three points; config changes after START must not matter
    res_q.delete(); gap_q.delete(); d0 = done_cnt;
    start_sweep(28'h0100000, 28'h1000, 10'd3, 16'd4);
    chk("sw_busy", 64'(BUSY), 1);
    chk("sw_out0", 64'(OUT), 64'h0100000);
    cfg_start = 28'h5555555; cfg_step = 28'h7; cfg_count = 10'd9;
    wait_done("sw_timeout", 2000);
    chk("sw_count", 64'(res_q.size()), 3);
    chk_res("sw0", 0, 10'd0, 28'h0100000);
    chk_res("sw1", 1, 10'd1, 28'h0101000);
    chk_res("sw2", 2, 10'd2, 28'h0102000);
    foreach (gap_q[k]) chk("sw_gap_ge4", 64'(gap_q[k] >= 4), 1);
    chk("sw_done_once", 64'(done_cnt - d0), 1);
    chk("sw_idle", 64'(BUSY), 0);

    // Backpressure on point 1
    res_q.delete(); READY = 1'b0;
    start_sweep(28'h0100000, 28'h1000, 10'd3, 16'd4);
    wait_valid("bp_v0", 500);
    READY = 1'b1;
    tick(1);
    READY = 1'b0;
    wait_valid("bp_v1", 500);
    snap = '{R_IDX, R_INC, R_SIN, R_COS};
    o_snap = OUT;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (!VALID || OUT != o_snap ||
          res_t'({R_IDX, R_INC, R_SIN, R_COS}) != snap) bad++;
    end
    chk("bp_stable", 64'(bad), 0);
    chk("bp_hold_idx", 64'(snap.idx), 1);
    tick(0);
    @(posedge CLK); #1;
    READY = 1'b1;
    wait_done("bp_timeout", 2000);
    chk("bp_count", 64'(res_q.size()), 3);
    chk_res("bp1", 1, 10'd1, 28'h0101000);
    chk_res("bp2", 2, 10'd2, 28'h0102000);

    // Zero count: DONE next clock, nothing issued
    res_q.delete(); d0 = done_cnt;
    start_sweep(28'h0000123, 28'h1, 10'd0, 16'd4);
    chk("z_done", 64'(DONE), 1);
    chk("z_busy", 64'(BUSY), 0);
    tick(1);
    chk("z_done_pulse", 64'(DONE), 0);
    tick(20);
    chk("z_noresult", 64'(res_q.size()), 0);
    chk("z_done_cnt", 64'(done_cnt - d0), 1);

    // Wrap-around step with zero settle
    res_q.delete(); gap_q.delete();
    start_sweep(28'hFFFFFFF, 28'h2, 10'd2, 16'd0);
    wait_done("wrap_timeout", 2000);
    chk("wrap_count", 64'(res_q.size()), 2);
    chk_res("wrap0", 0, 10'd0, 28'hFFFFFFF);
    chk_res("wrap1", 1, 10'd1, 28'h0000001);
    foreach (gap_q[k]) chk("s0_gap", 64'(gap_q[k]), 1);

    // Abort during SETTLE
    res_q.delete(); d0 = done_cnt;
    start_sweep(28'h0100000, 28'h1000, 10'd3, 16'd20);
    wait_match("ab1_match", 500);
    tick(2);
    ABORT = 1'b1;
    tick(1);
    ABORT = 1'b0;
    chk("ab1_busy", 64'(BUSY), 0);
    chk("ab1_valid", 64'(VALID), 0);
    chk("ab1_out", 64'(OUT), 64'h0100000);
    tick(100);
    chk("ab1_nodone", 64'(done_cnt - d0), 0);
    chk("ab1_nores", 64'(res_q.size()), 0);

    // Abort with a same-cycle handshake in OUTPUT
    READY = 1'b0;
    start_sweep(28'h0300000, 28'h1000, 10'd3, 16'd1);
    wait_valid("ab2_valid", 500);
    READY = 1'b1; ABORT = 1'b1;
    tick(1);
    ABORT = 1'b0;
    chk("ab2_valid", 64'(VALID), 0);
    chk("ab2_busy", 64'(BUSY), 0);
    chk("ab2_out", 64'(OUT), 64'h0300000);
    tick(10);
    chk("ab2_nores", 64'(res_q.size()), 0);
    chk("ab2_nodone", 64'(done_cnt - d0), 0);
    start_sweep(28'h0200000, 28'h1000, 10'd1, 16'd2);
    wait_done("ab2_restart", 2000);
    chk("ab2_rcount", 64'(res_q.size()), 1);
    chk_res("ab2_r", 0, 10'd0, 28'h0200000);

    // CE held low for 100 clocks in SETTLE
    res_q.delete(); gap_q.delete();
    start_sweep(28'h0400000, 28'h1000, 10'd1, 16'd4);
    wait_match("ce_match", 500);
    tick(1);
    ce_en = 1'b0;
    o_snap = OUT;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (!BUSY || VALID || DONE || OUT != o_snap) bad++;
    end
    chk("ce_frozen", 64'(bad), 0);
    tick(0);
    @(posedge CLK); #1;
    ce_en = 1'b1;
    wait_done("ce_timeout", 2000);
    chk("ce_count", 64'(res_q.size()), 1);
    chk_res("ce0", 0, 10'd0, 28'h0400000);
    foreach (gap_q[k]) chk("ce_gap_ge4", 64'(gap_q[k] >= 4), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
